// File: rtl/ifetch_buffer.sv
// ifetch_buffer: single-outstanding instruction fetcher feeding a DEPTH-entry prefetch queue.
// Define IFETCH_BYPASS_EN to let a response reach deq_* in the same cycle when the queue is empty.
module ifetch_buffer #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_pc,
  output logic [31:0] deq_inst
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n, pend_pc, pend_pc_n, redirect_word;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic land, bypass, push, pop, flush;
  assign redirect_word = {redirect_pc[31:2], 2'b00};
  assign imem_addr = fetch_pc;
  assign imem_rmask = state == IDLE ? 4'h0 : 4'hf;
  assign land = state == WAIT && imem_resp && !redirect_valid;
  assign pop = count != '0 && deq_ready;
  assign push = land && !bypass;
  // DRAIN entered with an empty queue and never pushes, so it needs no flush
  assign flush = redirect_valid && state != DRAIN;
`ifdef IFETCH_BYPASS_EN
  assign bypass = land && count == '0 && deq_ready;
  assign deq_valid = count != '0 || (land && count == '0);
  assign deq_pc = count != '0 ? pc_q[head] : fetch_pc;
  assign deq_inst = count != '0 ? inst_q[head] : imem_rdata;
`else
  assign bypass = 1'b0;
  assign deq_valid = count != '0;
  assign deq_pc = pc_q[head];
  assign deq_inst = inst_q[head];
`endif
  always_comb begin
    state_n = state;
    fetch_pc_n = fetch_pc;
    pend_pc_n = pend_pc;
    case (state)
      IDLE: begin
        if (redirect_valid) fetch_pc_n = redirect_word;
        else if (count < CW'(DEPTH)) state_n = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_n = imem_resp ? IDLE : DRAIN;
          fetch_pc_n = imem_resp ? redirect_word : fetch_pc;
          pend_pc_n = redirect_word;
        end else if (imem_resp) begin
          state_n = IDLE;
          fetch_pc_n = fetch_pc + 32'd4;
        end
      end
      DRAIN: begin
        // the stale address stays on the bus until its response retires
        if (redirect_valid) pend_pc_n = redirect_word;
        if (imem_resp) begin
          state_n = IDLE;
          fetch_pc_n = redirect_valid ? redirect_word : pend_pc;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      pend_pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      pend_pc <= pend_pc_n;
      if (flush) begin
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        head <= head + AW'(pop);
        tail <= tail + AW'(push);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail] <= fetch_pc;
      inst_q[tail] <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed vector table, scenario sequences and randomized traffic checked against a queue-based model.
module tb_ifetch_buffer;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h1eceb000;
  logic clk = 0, rst = 1;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, deq_pc, deq_inst;
  logic [3:0] imem_rmask;
  logic imem_resp = 0, redirect_valid = 0, deq_valid, deq_ready = 0;
  int checks = 0, errors = 0;
  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_inst(deq_inst));
  always #5 clk = ~clk;
  typedef struct { logic [31:0] pc, inst; } ent_t;
  typedef struct {
    logic r, resp; logic [31:0] rdata; logic rv; logic [31:0] rpc; logic rdy;
    logic chk; logic [3:0] rmask; logic [31:0] addr; logic dv; logic [31:0] dpc, dinst;
  } vec_t;
  ent_t mq[$];
  logic [31:0] popped[$];
  int m_mode = 0;
  logic [31:0] m_fpc = RPC, m_pend = RPC, first_req = 0;
  bit m_known = 0, mdup = 0, lat_rand = 0, saw_req = 0;
  int mwait = 0, lat = 1, dup_pct = 0, live_resps = 0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic mupdate();
    int sz;
    bit pop;
    ent_t e;
    if (rst) begin
      mq.delete(); m_mode = 0; m_fpc = RPC; m_known = 1; saw_req = 0;
      return;
    end
    sz = mq.size();
    pop = sz != 0 && deq_ready;
    if (m_mode == 0) begin
      if (redirect_valid) begin mq.delete(); m_fpc = redirect_pc & ~32'h3; end
      else begin
        if (pop) void'(mq.pop_front());
        if (sz < DEPTH) m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (redirect_valid) begin
        mq.delete();
        if (imem_resp) begin m_fpc = redirect_pc & ~32'h3; m_mode = 0; end
        else begin m_pend = redirect_pc & ~32'h3; m_mode = 2; end
      end else begin
        if (pop) void'(mq.pop_front());
        if (imem_resp) begin
          e.pc = m_fpc; e.inst = imem_rdata;
          mq.push_back(e); m_fpc = m_fpc + 4; m_mode = 0;
        end
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (redirect_valid) m_pend = redirect_pc & ~32'h3;
      if (imem_resp) begin m_fpc = m_pend; m_mode = 0; end
    end
  endtask
  task automatic rstep(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; deq_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    if (mdup) begin imem_resp = 1; imem_rdata = $urandom; mdup = 0; end
    else if (imem_rmask == 4'hf) begin
      if (mwait == 0 && lat_rand) lat = $urandom_range(1, 4);
      mwait++;
      if (mwait >= lat) begin
        imem_resp = 1; imem_rdata = word(imem_addr); mwait = 0; live_resps++;
        mdup = $urandom_range(99) < dup_pct;
      end else imem_resp = 0;
    end else begin imem_resp = 0; mwait = 0; end
    if (m_known) begin
      chk("rmask", {28'h0, imem_rmask}, m_mode != 0 ? 32'hf : 32'h0);
      chk("addr", imem_addr, m_fpc);
      chk("deq_valid", {31'h0, deq_valid}, {31'h0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("deq_pc", deq_pc, mq[0].pc);
        chk("deq_inst", deq_inst, mq[0].inst);
      end
      if (!saw_req && imem_rmask == 4'hf) begin first_req = imem_addr; saw_req = 1; end
      if (deq_valid && deq_ready) popped.push_back(deq_pc);
    end
    @(posedge clk);
    mupdate();
  endtask
  task automatic do_reset();
    rstep(1, 0, 0, 0);
    rstep(1, 0, 0, 0);
    popped.delete(); live_resps = 0;
  endtask
  vec_t vt[19];
  function automatic vec_t v(input logic r, resp, input logic [31:0] rdata, input logic rv,
      input logic [31:0] rpc, input logic rdy, chk, input logic [3:0] rmask,
      input logic [31:0] addr, input logic dv, input logic [31:0] dpc, dinst);
    vec_t x;
    x.r = r; x.resp = resp; x.rdata = rdata; x.rv = rv; x.rpc = rpc; x.rdy = rdy; x.chk = chk;
    x.rmask = rmask; x.addr = addr; x.dv = dv; x.dpc = dpc; x.dinst = dinst;
    return x;
  endfunction
  initial begin
    vt[0]  = v(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    vt[1]  = v(1, 0, 0, 0, 0, 0, 1, 4'h0, RPC, 0, 0, 0);
    vt[2]  = v(0, 0, 0, 0, 0, 0, 1, 4'h0, RPC, 0, 0, 0);
    vt[3]  = v(0, 0, 0, 0, 0, 0, 1, 4'hf, RPC, 0, 0, 0);
    vt[4]  = v(0, 1, 32'haaaa0000, 0, 0, 0, 1, 4'hf, RPC, 0, 0, 0);
    vt[5]  = v(0, 1, 32'h0bad0bad, 0, 0, 0, 1, 4'h0, RPC + 4, 1, RPC, 32'haaaa0000);
    vt[6]  = v(0, 0, 0, 0, 0, 0, 1, 4'hf, RPC + 4, 1, RPC, 32'haaaa0000);
    vt[7]  = v(0, 0, 0, 1, 32'h00002003, 0, 1, 4'hf, RPC + 4, 1, RPC, 32'haaaa0000);
    vt[8]  = v(0, 0, 0, 1, 32'h00003001, 0, 1, 4'hf, RPC + 4, 0, 0, 0);
    vt[9]  = v(0, 1, 32'h0bad0bad, 0, 0, 0, 1, 4'hf, RPC + 4, 0, 0, 0);
    vt[10] = v(0, 0, 0, 0, 0, 0, 1, 4'h0, 32'h3000, 0, 0, 0);
    vt[11] = v(0, 1, 32'hbbbb0001, 0, 0, 1, 1, 4'hf, 32'h3000, 0, 0, 0);
    vt[12] = v(0, 0, 0, 0, 0, 1, 1, 4'h0, 32'h3004, 1, 32'h3000, 32'hbbbb0001);
    vt[13] = v(0, 1, 32'hcccc0002, 1, 32'h00005002, 0, 1, 4'hf, 32'h3004, 0, 0, 0);
    vt[14] = v(0, 0, 0, 1, 32'h00006003, 0, 1, 4'h0, 32'h5000, 0, 0, 0);
    vt[15] = v(0, 0, 0, 0, 0, 0, 1, 4'h0, 32'h6000, 0, 0, 0);
    vt[16] = v(1, 0, 0, 0, 0, 0, 1, 4'hf, 32'h6000, 0, 0, 0);
    vt[17] = v(0, 0, 0, 0, 0, 0, 1, 4'h0, RPC, 0, 0, 0);
    vt[18] = v(0, 0, 0, 0, 0, 0, 1, 4'hf, RPC, 0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst = vt[i].r; imem_resp = vt[i].resp; imem_rdata = vt[i].rdata;
      redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc; deq_ready = vt[i].rdy;
      if (vt[i].chk) begin
        chk($sformatf("v%0d_rmask", i), {28'h0, imem_rmask}, {28'h0, vt[i].rmask});
        chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
        chk($sformatf("v%0d_dv", i), {31'h0, deq_valid}, {31'h0, vt[i].dv});
        if (vt[i].dv) begin
          chk($sformatf("v%0d_dpc", i), deq_pc, vt[i].dpc);
          chk($sformatf("v%0d_dinst", i), deq_inst, vt[i].dinst);
        end
      end
    end
    imem_resp = 0; redirect_valid = 0;
    // in-order stream, latency 5, consumer always ready
    lat = 5; dup_pct = 0; lat_rand = 0;
    do_reset();
    for (int i = 0; i < 40; i++) rstep(0, 1, 0, 0);
    chk("first_req", first_req, RPC);
    chk("npop_ge3", {31'h0, popped.size() >= 3}, 32'h1);
    if (popped.size() >= 3)
      for (int i = 0; i < 3; i++) chk($sformatf("seq_pc%0d", i), popped[i], RPC + 32'(4 * i));
    // backpressure: queue fills to DEPTH, then one pop allows one request
    lat = 2; dup_pct = 100;
    do_reset();
    for (int i = 0; i < 40; i++) rstep(0, 0, 0, 0);
    chk("fill_reqs", live_resps, DEPTH);
    chk("fill_rmask", {28'h0, imem_rmask}, 32'h0);
    chk("fill_dv", {31'h0, deq_valid}, 32'h1);
    rstep(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) rstep(0, 0, 0, 0);
    chk("refill_reqs", live_resps, DEPTH + 1);
    // randomized traffic with duplicate responses, redirects and resets
    lat_rand = 1; dup_pct = 50;
    do_reset();
    for (int i = 0; i < 3000; i++)
      rstep($urandom_range(199) == 0, 1'($urandom_range(1)), $urandom_range(19) == 0, $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
